pipeline_ctrl: RTL
==================

// Module: pipeline_ctrl
// PURPOSE
// Sequencer for the 5-stage MIPS pipeline latches (PC, IF/ID, ID/EX). Gates the global pipe enable
// from debug-unit run/step commands, detects load-use hazards and stalls PC + IF/ID while bubbling ID/EX,
// flushes IF/ID on taken jumps, and drains the pipeline after a HALT reaches ID. Sits between debug unit and datapath.
// PARAMETERS
// DRAIN_CYCLES  4   enabled cycles after HALT-in-ID before HALTED (HALT through EX/MEM/WB + margin)
// CNT_W         32  width of executed-cycle counter
// REG_W         5   register address width
// PORTS
// clk              in   1      clock
// rst              in   1      asynchronous reset, active-high
// i_run            in   1      pulse: start continuous execution
// i_step           in   1      pulse: execute exactly one cycle
// i_clear          in   1      pulse: zero cycle counter, HALTED->IDLE
// i_halt_id        in   1      HALT opcode decoded in ID
// i_jump_taken     in   1      jump/branch resolved taken in ID
// i_id_ex_mem_read in   1      instruction in EX is a load
// i_id_ex_rt       in   REG_W  load destination in EX
// i_if_id_rs       in   REG_W  rs of instruction in ID
// i_if_id_rt       in   REG_W  rt of instruction in ID
// o_pipe_enable    out  1      clock-enable for all pipeline latches this cycle
// o_pc_write       out  1      PC update enable
// o_if_id_write    out  1      IF/ID latch write enable
// o_if_id_flush    out  1      IF/ID clear (NOP insert)
// o_id_ex_bubble   out  1      zero ID/EX control signals
// o_halted         out  1      pipeline drained after HALT
// o_cycle_cnt      out  CNT_W  enabled cycles executed, saturating
// BEHAVIOUR
// - States: IDLE, RUN, STEP, DRAIN, HALTED. Reset (async): state=IDLE, drain_cnt=0, o_cycle_cnt=0; all outputs 0.
// - IDLE: enable=0. i_run->RUN; else i_step->STEP (i_run wins if both). i_clear zeroes counter, stays IDLE.
// - STEP: enable=1 for exactly one cycle, then IDLE; if i_halt_id that cycle ->DRAIN. i_run/i_step ignored in STEP.
// - RUN: enable=1 every cycle; i_step ignored; i_halt_id (not stalled) ->DRAIN next cycle.
// - DRAIN: enable=1, pc_write=0, if_id_flush=1, hazards ignored; drain_cnt counts 1..DRAIN_CYCLES, then HALTED.
// - HALTED: enable=0, o_halted=1; i_run/i_step ignored; i_clear -> IDLE, counter=0, o_halted=0 next cycle.
// - Decode outputs combinational from state+inputs; all outputs 0 whenever enable=0.
// - hazard = mem_read && ex_rt!=0 && (ex_rt==if_id_rs || ex_rt==if_id_rt).
// - RUN/STEP, hazard=1: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0 (stall beats flush;
//   jump re-resolves next cycle), i_halt_id not acted on (HALT held, acted next cycle).
// - RUN/STEP, hazard=0: pc_write=1, if_id_write=1, if_id_flush=i_jump_taken, bubble=0.
// - HALT and jump same cycle: HALT wins (enter DRAIN), flush still asserted.
// - o_cycle_cnt +1 on every cycle with enable=1 (incl. stall/drain), saturates at 2^CNT_W-1.
// - Latency: command pulse at edge N -> enable high in cycle N+1. Reset mid-run aborts immediately to IDLE.
// - i_clear in RUN/STEP/DRAIN: counter zeroed only; state unaffected.
// STRUCTURE
// - pipeline_defs.vh: state encodings (3-bit localparams), NOP encoding, REG_W default.
// - Sub-module hazard_unit (combinational load-use compare); FSM, drain counter, cycle counter here.
// TESTING
// - Reset mid-RUN (rst pulse) -> state IDLE, all outputs 0, o_cycle_cnt=0 same cycle (async).
// - IDLE, i_step x3 -> exactly 3 enable cycles, o_cycle_cnt=3, back in IDLE each time.
// - RUN, mem_read=1, ex_rt=8, if_id_rs=8 for 1 cycle -> pc_write=0, if_id_write=0, bubble=1; ex_rt=0 -> no stall.
// - RUN, i_jump_taken=1 with hazard=1 -> flush=0; next cycle hazard=0 jump=1 -> flush=1, pc_write=1.
// - RUN, i_halt_id=1 -> 4 DRAIN cycles (pc_write=0, flush=1) then o_halted=1, enable=0; i_run ignored.
// - HALTED, i_clear -> IDLE, counter=0; CNT_W=4 run 20 cycles -> o_cycle_cnt holds 15.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and defaults for the pipeline sequencer: FSM state encoding,
// per-cycle latch-control bundle and parameter defaults.
package pipeline_ctrl_pkg;

    localparam int unsigned REG_W_DEF        = 5;
    localparam int unsigned CNT_W_DEF        = 32;
    localparam int unsigned DRAIN_CYCLES_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_e;

    // Latch controls decoded each cycle from state plus datapath status.
    typedef struct packed {
        logic pipe_enable;
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_bubble;
    } ctrl_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Debug-unit commands, datapath status and latch controls of the pipeline sequencer.
interface pipeline_ctrl_if #(
    parameter int unsigned REG_W = pipeline_ctrl_pkg::REG_W_DEF,
    parameter int unsigned CNT_W = pipeline_ctrl_pkg::CNT_W_DEF
);
    logic             i_run;
    logic             i_step;
    logic             i_clear;
    logic             i_halt_id;
    logic             i_jump_taken;
    logic             i_id_ex_mem_read;
    logic [REG_W-1:0] i_id_ex_rt;
    logic [REG_W-1:0] i_if_id_rs;
    logic [REG_W-1:0] i_if_id_rt;
    logic             o_pipe_enable;
    logic             o_pc_write;
    logic             o_if_id_write;
    logic             o_if_id_flush;
    logic             o_id_ex_bubble;
    logic             o_halted;
    logic [CNT_W-1:0] o_cycle_cnt;

    modport master (
        output i_run, i_step, i_clear, i_halt_id, i_jump_taken,
               i_id_ex_mem_read, i_id_ex_rt, i_if_id_rs, i_if_id_rt,
        input  o_pipe_enable, o_pc_write, o_if_id_write, o_if_id_flush,
               o_id_ex_bubble, o_halted, o_cycle_cnt
    );

    modport slave (
        input  i_run, i_step, i_clear, i_halt_id, i_jump_taken,
               i_id_ex_mem_read, i_id_ex_rt, i_if_id_rs, i_if_id_rt,
        output o_pipe_enable, o_pc_write, o_if_id_write, o_if_id_flush,
               o_id_ex_bubble, o_halted, o_cycle_cnt
    );
endinterface

// File: rtl/pipeline_ctrl_hazard_unit.sv
// Load-use hazard detect: a load in EX whose destination feeds the instruction in ID.
module pipeline_ctrl_hazard_unit #(
    parameter int unsigned REG_W = pipeline_ctrl_pkg::REG_W_DEF
) (
    input  logic             mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] if_id_rs,
    input  logic [REG_W-1:0] if_id_rt,
    output logic             hazard_c
);
    // $zero is never a real dependency.
    assign hazard_c = mem_read && (ex_rt != '0) &&
                      ((ex_rt == if_id_rs) || (ex_rt == if_id_rt));
endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: run/step gating, load-use stall, jump flush, HALT drain
// and saturating count of enabled cycles.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned REG_W        = REG_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    pipeline_ctrl_if.slave bus
);
    localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1);

    state_e           state_q, state_d;
    logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic             hazard_c;
    ctrl_t            ctrl_c;
    logic             halt_go_c;

    pipeline_ctrl_hazard_unit #(.REG_W(REG_W)) u_hazard (
        .mem_read (bus.i_id_ex_mem_read),
        .ex_rt    (bus.i_id_ex_rt),
        .if_id_rs (bus.i_if_id_rs),
        .if_id_rt (bus.i_if_id_rt),
        .hazard_c (hazard_c)
    );

    // A stalled HALT stays in ID and is acted on once the stall clears.
    assign halt_go_c = bus.i_halt_id && !hazard_c;

    // Latch-control decode; everything stays low while the pipe is frozen.
    always_comb begin
        ctrl_c = '0;
        unique case (state_q)
            ST_RUN, ST_STEP: begin
                ctrl_c.pipe_enable = 1'b1;
                if (hazard_c) begin
                    ctrl_c.id_ex_bubble = 1'b1;
                end else begin
                    ctrl_c.pc_write    = 1'b1;
                    ctrl_c.if_id_write = 1'b1;
                    ctrl_c.if_id_flush = bus.i_jump_taken;
                end
            end
            ST_DRAIN: begin
                ctrl_c.pipe_enable = 1'b1;
                ctrl_c.if_id_flush = 1'b1;
            end
            default: ;
        endcase
    end

    // Next state, drain counter and cycle counter.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        if (ctrl_c.pipe_enable && (cycle_cnt_q != '1)) begin
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end
        if (bus.i_clear) begin
            cycle_cnt_d = '0;
        end
        unique case (state_q)
            ST_IDLE: begin
                if (bus.i_run)       state_d = ST_RUN;
                else if (bus.i_step) state_d = ST_STEP;
            end
            ST_STEP: begin
                state_d     = halt_go_c ? ST_DRAIN : ST_IDLE;
                drain_cnt_d = '0;
            end
            ST_RUN: begin
                if (halt_go_c) state_d = ST_DRAIN;
                drain_cnt_d = '0;
            end
            ST_DRAIN: begin
                if (drain_cnt_q == DW'(DRAIN_CYCLES - 1)) begin
                    state_d     = ST_HALTED;
                    drain_cnt_d = '0;
                end else begin
                    drain_cnt_d = drain_cnt_q + DW'(1);
                end
            end
            ST_HALTED: begin
                if (bus.i_clear) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            drain_cnt_q <= '0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign bus.o_pipe_enable  = ctrl_c.pipe_enable;
    assign bus.o_pc_write     = ctrl_c.pc_write;
    assign bus.o_if_id_write  = ctrl_c.if_id_write;
    assign bus.o_if_id_flush  = ctrl_c.if_id_flush;
    assign bus.o_id_ex_bubble = ctrl_c.id_ex_bubble;
    assign bus.o_halted       = (state_q == ST_HALTED);
    assign bus.o_cycle_cnt    = cycle_cnt_q;

endmodule
